// File: rtl/weight_code_generator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : weight_code_pkg
//  Description : Shared types and helpers for the weight code generator.
//                - gen_state_t : generator FSM states.
//                - popcount()  : population count of a word of up to
//                                c_POP_MAX_W bits. Callers zero-extend
//                                narrower words and truncate the result to
//                                their own $clog2(WIDTH+1) bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package weight_code_pkg;

    // Package functions cannot see a module parameter, so popcount works on
    // a fixed maximum width. Zero-extending a word does not change its count.
    localparam int c_POP_MAX_W = 32;
    localparam int c_POP_OUT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } gen_state_t;

    function automatic logic [c_POP_OUT_W-1:0] popcount(
        input logic [c_POP_MAX_W-1:0] word
    );
        logic [c_POP_OUT_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < c_POP_MAX_W; i++) begin
            acc = acc + {{(c_POP_OUT_W-1){1'b0}}, word[i]};
        end
        return acc;
    endfunction

endpackage : weight_code_pkg
`default_nettype wire

// File: rtl/weight_code_generator_window_check.sv
`default_nettype none
// ============================================================================
//  Module      : weight_window_check
//  Description : Combinational test of whether the population count of a
//                word lies in [MIN_W, MAX_W] (unsigned). With the default
//                parameters this is the 2-or-3-of-4 weight detector.
//  Ports       : i_word      [WIDTH-1:0]  candidate word
//                o_in_window              1 when MIN_W <= popcount <= MAX_W
//  Revision    : 1.0 - initial release
// ============================================================================
module weight_window_check
    import weight_code_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MIN_W = 2,
    parameter int MAX_W = 3
) (
    input  logic [WIDTH-1:0] i_word,
    output logic             o_in_window
);

    localparam int PCW = $clog2(WIDTH + 1);

    logic [c_POP_MAX_W-1:0] w_word_ext;
    logic [PCW-1:0]         w_pc;
    logic                   w_lo_ok;
    logic                   w_hi_ok;

    always_comb begin
        w_word_ext              = '0;
        w_word_ext[WIDTH-1:0]   = i_word;
    end

    assign w_pc = PCW'(popcount(w_word_ext));

    // Bounds that can never reject a word are resolved at elaboration so no
    // constant-result comparison is built.
    if (MIN_W == 0) begin : g_lo_open
        assign w_lo_ok = 1'b1;
    end else begin : g_lo_cmp
        localparam logic [PCW-1:0] c_MIN = PCW'(MIN_W);
        assign w_lo_ok = (w_pc >= c_MIN);
    end

    if (MAX_W >= WIDTH) begin : g_hi_open
        assign w_hi_ok = 1'b1;
    end else begin : g_hi_cmp
        localparam logic [PCW-1:0] c_MAX = PCW'(MAX_W);
        assign w_hi_ok = (w_pc <= c_MAX);
    end

    assign o_in_window = w_lo_ok && w_hi_ok;

endmodule : weight_window_check
`default_nettype wire

// File: rtl/weight_code_generator.sv
`default_nettype none
// ============================================================================
//  Module      : weight_code_generator
//  Description : On a start pulse, walks every WIDTH-bit word in ascending
//                order and emits, one per valid/ready handshake, each word
//                whose popcount lies in [MIN_W, MAX_W]. Reports the number of
//                words emitted and pulses done when the walk finishes.
//  Ports       : clk, rst (sync, active high)
//                start              begin a run (honoured only in IDLE)
//                o_data [WIDTH-1:0] emitted codeword
//                o_valid            o_data holds a codeword
//                o_ready            consumer accepts o_data
//                busy               high in SCAN or EMIT
//                done               one-cycle pulse at end of run
//                count  [WIDTH:0]   words emitted in current/last run
//  Revision    : 1.0 - initial release
// ============================================================================
module weight_code_generator
    import weight_code_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MIN_W = 2,
    parameter int MAX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   count
);

    localparam logic [WIDTH-1:0] c_CAND_ONE  = WIDTH'(1);
    localparam logic [WIDTH:0]   c_COUNT_ONE = (WIDTH+1)'(1);

    gen_state_t       r_state;
    gen_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] w_cand_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [WIDTH:0]   r_count;
    logic [WIDTH:0]   w_count_nxt;

    logic             w_in_window;
    logic             w_cand_last;

    weight_window_check #(
        .WIDTH (WIDTH),
        .MIN_W (MIN_W),
        .MAX_W (MAX_W)
    ) u_window (
        .i_word      (r_cand),
        .o_in_window (w_in_window)
    );

    // Termination compares against all-ones; r_cand is never incremented
    // past it, so it cannot wrap.
    assign w_cand_last = (r_cand == {WIDTH{1'b1}});

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_count_nxt = r_count;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_cand_nxt  = '0;
                    w_count_nxt = '0;
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (w_in_window) begin
                    w_data_nxt  = r_cand;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = EMIT;
                end else if (w_cand_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cand_nxt  = r_cand + c_CAND_ONE;
                end
            end
            EMIT: begin
                // o_data/o_valid simply hold until the consumer takes the word.
                if (r_valid && o_ready) begin
                    w_valid_nxt = 1'b0;
                    w_count_nxt = r_count + c_COUNT_ONE;
                    if (w_cand_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_cand_nxt  = r_cand + c_CAND_ONE;
                        w_state_nxt = SCAN;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Status flops are loaded from the next state so they line up
        // exactly with the state they describe.
        w_busy_nxt = (w_state_nxt == SCAN) || (w_state_nxt == EMIT);
        w_done_nxt = (w_state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cand  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign busy    = r_busy;
    assign done    = r_done;
    assign count   = r_count;

endmodule : weight_code_generator
`default_nettype wire

// File: tb/tb_weight_code_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_weight_code_generator
//  Description : Directed self-checking bench. Three generator instances:
//                defaults (2..3), window 4..4 and window 0..0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_code_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic       start, rdy, valid, busy, done;
    logic [3:0] data;
    logic [4:0] count;

    logic       start44, rdy44, valid44, busy44, done44;
    logic [3:0] data44;
    logic [4:0] count44;

    logic       start00, rdy00, valid00, busy00, done00;
    logic [3:0] data00;
    logic [4:0] count00;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_seq [10] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9,
                                 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};

    weight_code_generator #(.WIDTH(4), .MIN_W(2), .MAX_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .o_data(data), .o_valid(valid),
        .o_ready(rdy), .busy(busy), .done(done), .count(count));

    weight_code_generator #(.WIDTH(4), .MIN_W(4), .MAX_W(4)) dut44 (
        .clk(clk), .rst(rst), .start(start44), .o_data(data44), .o_valid(valid44),
        .o_ready(rdy44), .busy(busy44), .done(done44), .count(count44));

    weight_code_generator #(.WIDTH(4), .MIN_W(0), .MAX_W(0)) dut00 (
        .clk(clk), .rst(rst), .start(start00), .o_data(data00), .o_valid(valid00),
        .o_ready(rdy00), .busy(busy00), .done(done00), .count(count00));

    // Drives one run of the default instance and records what it emits.
    // Returns at the negedge where done is first seen (or on timeout).
    // stall: cycles o_ready is held low after each new word appears.
    // spam : keep start asserted for the whole run.
    task automatic run_default(input int stall, input logic spam,
                               output int n, output logic [3:0] w [16],
                               output int nstall_bad, output logic timeout);
        int         st;
        logic [3:0] held;
        logic       prev_valid, prev_acc;
        n = 0; nstall_bad = 0; timeout = 1'b0;
        st = 0; held = '0; prev_valid = 1'b0; prev_acc = 1'b0;
        for (int i = 0; i < 16; i++) w[i] = '0;
        rdy = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = spam;
        for (int cyc = 0; ; cyc++) begin
            if (done) break;
            if (cyc > 600) begin timeout = 1'b1; break; end
            if (valid) begin
                if (!prev_valid || prev_acc) begin
                    held = data; st = stall;
                end else if (data !== held) begin
                    nstall_bad++;
                end
                if (st > 0) begin
                    rdy = 1'b0; st--; prev_acc = 1'b0;
                end else begin
                    rdy = 1'b1; prev_acc = 1'b1;
                    if (n < 16) w[n] = data;
                    n++;
                end
            end else begin
                if (prev_valid && !prev_acc) nstall_bad++;
                rdy = 1'b1; prev_acc = 1'b0;
            end
            prev_valid = valid;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start44 = 1'b0; start00 = 1'b0;
        rdy = 1'b1; rdy44 = 1'b1; rdy00 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({valid, busy, done, data, count} !== 12'd0) begin
            errors++;
            $display("FAIL reset_default: got v=%0b b=%0b d=%0b data=%0d cnt=%0d expected all 0",
                     valid, busy, done, data, count);
        end
        checks++;
        if ({valid44, busy44, done44, data44, count44} !== 12'd0) begin
            errors++;
            $display("FAIL reset_44: got v=%0b b=%0b d=%0b data=%0d cnt=%0d expected all 0",
                     valid44, busy44, done44, data44, count44);
        end
        checks++;
        if ({valid00, busy00, done00, data00, count00} !== 12'd0) begin
            errors++;
            $display("FAIL reset_00: got v=%0b b=%0b d=%0b data=%0d cnt=%0d expected all 0",
                     valid00, busy00, done00, data00, count00);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ready_tied();
        int n, bad, extra; logic to; logic [3:0] w [16];
        run_default(0, 1'b0, n, w, bad, to);
        checks++;
        if (to) begin errors++; $display("FAIL tied_timeout: got no done, expected done"); end
        checks++;
        if (n != 10) begin errors++; $display("FAIL tied_nwords: got %0d expected 10", n); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (w[i] !== exp_seq[i]) begin
                errors++;
                $display("FAIL tied_word[%0d]: got %0d expected %0d", i, w[i], exp_seq[i]);
            end
        end
        checks++;
        if (count !== 5'd10 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tied_at_done: got count=%0d busy=%0b expected count=10 busy=0", count, busy);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++;
        if (extra != 0 || count !== 5'd10) begin
            errors++;
            $display("FAIL tied_after_done: got %0d extra done/busy cycles count=%0d expected 0 and 10",
                     extra, count);
        end
    endtask

    task automatic test_backpressure();
        int n, bad; logic to; logic [3:0] w [16];
        run_default(7, 1'b0, n, w, bad, to);
        checks++;
        if (to) begin errors++; $display("FAIL bp_timeout: got no done, expected done"); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d unstable cycles expected 0", bad); end
        checks++;
        if (n != 10) begin errors++; $display("FAIL bp_nwords: got %0d expected 10", n); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (w[i] !== exp_seq[i]) begin
                errors++;
                $display("FAIL bp_word[%0d]: got %0d expected %0d", i, w[i], exp_seq[i]);
            end
        end
        checks++;
        if (count !== 5'd10) begin errors++; $display("FAIL bp_count: got %0d expected 10", count); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_window_44();
        int n, hs, dc; logic [3:0] w0;
        n = 0; hs = -1; dc = -1; w0 = '0;
        @(negedge clk); start44 = 1'b1;
        @(negedge clk); start44 = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (valid44) begin if (n == 0) w0 = data44; n++; hs = c; end
            if (done44) begin dc = c; break; end
            @(negedge clk);
        end
        checks++;
        if (n != 1 || w0 !== 4'd15) begin
            errors++;
            $display("FAIL w44_words: got n=%0d first=%0d expected n=1 first=15", n, w0);
        end
        checks++;
        if (hs != 16 || dc != 17) begin
            errors++;
            $display("FAIL w44_timing: got handshake@%0d done@%0d expected 16 and 17", hs, dc);
        end
        checks++;
        if (count44 !== 5'd1) begin errors++; $display("FAIL w44_count: got %0d expected 1", count44); end
        @(negedge clk);
        checks++;
        if (done44 !== 1'b0 || busy44 !== 1'b0) begin
            errors++;
            $display("FAIL w44_after: got done=%0b busy=%0b expected 0 0", done44, busy44);
        end
    endtask

    task automatic test_window_00();
        int n, hs, dc, ndone; logic [3:0] w0;
        n = 0; hs = -1; dc = -1; w0 = 4'hF; ndone = 0;
        @(negedge clk); start00 = 1'b1;
        @(negedge clk); start00 = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (valid00) begin if (n == 0) w0 = data00; n++; hs = c; end
            if (done00) begin dc = c; break; end
            @(negedge clk);
        end
        checks++;
        if (n != 1 || w0 !== 4'd0) begin
            errors++;
            $display("FAIL w00_words: got n=%0d first=%0d expected n=1 first=0", n, w0);
        end
        checks++;
        if (hs != 1 || dc != 17) begin
            errors++;
            $display("FAIL w00_timing: got handshake@%0d done@%0d expected 1 and 17", hs, dc);
        end
        repeat (5) begin
            @(negedge clk);
            if (done00) ndone++;
        end
        checks++;
        if (ndone != 0 || count00 !== 5'd1) begin
            errors++;
            $display("FAIL w00_after: got extra_done=%0d count=%0d expected 0 and 1", ndone, count00);
        end
    endtask

    task automatic test_reset_mid_run();
        int n, bad; logic to, found; logic [3:0] w [16];
        found = 1'b0; rdy = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (valid && data == 4'd6) begin found = 1'b1; rdy = 1'b0; break; end
            @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mid_reach6: got no word 6 expected word 6"); end
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || data !== 4'd6) begin
            errors++;
            $display("FAIL mid_hold6: got v=%0b data=%0d expected v=1 data=6", valid, data);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || count !== 5'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%0b b=%0b cnt=%0d d=%0b expected 0 0 0 0",
                     valid, busy, count, done);
        end
        rst = 1'b0; rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_done: got done=%0b busy=%0b expected 0 0", done, busy);
        end
        run_default(0, 1'b0, n, w, bad, to);
        checks++;
        if (to || n != 10 || w[0] !== 4'd3 || w[9] !== 4'd14) begin
            errors++;
            $display("FAIL mid_rerun: got n=%0d first=%0d last=%0d to=%0b expected 10 3 14 0",
                     n, w[0], w[9], to);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start_spam();
        int n, bad, busy_cycles; logic to; logic [3:0] w [16];
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL spam_rst_wins: got busy=%0b valid=%0b expected 0 0", busy, valid);
        end
        run_default(0, 1'b1, n, w, bad, to);
        checks++;
        if (to || n != 10) begin
            errors++;
            $display("FAIL spam_nwords: got %0d to=%0b expected 10 0", n, to);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (w[i] !== exp_seq[i]) begin
                errors++;
                $display("FAIL spam_word[%0d]: got %0d expected %0d", i, w[i], exp_seq[i]);
            end
        end
        // start stayed high through the DONE cycle; it must not launch a run.
        @(negedge clk); start = 1'b0;
        busy_cycles = 0;
        repeat (4) begin
            if (busy || done) busy_cycles++;
            @(negedge clk);
        end
        checks++;
        if (busy_cycles != 0 || count !== 5'd10) begin
            errors++;
            $display("FAIL spam_no_requeue: got %0d busy/done cycles count=%0d expected 0 and 10",
                     busy_cycles, count);
        end
    endtask

    initial begin
        test_reset();
        test_ready_tied();
        test_backpressure();
        test_window_44();
        test_window_00();
        test_reset_mid_run();
        test_start_spam();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_weight_code_generator
`default_nettype wire
